// File: rtl/reverb_dl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reverb_dl_pkg
//  Purpose  : Shared constants and FSM state type for the reverb delay-line
//             sequencer and its address helper.
//  Revision : 1.0 - initial release
// ============================================================================
package reverb_dl_pkg;

    localparam int DEPTH     = 250000;  // delay-line length in 64-bit words
    localparam int ADDR_W    = 18;      // memory address width
    localparam int DATA_W    = 64;      // {left[63:32], right[31:0]}
    localparam int NUM_TAPS  = 8;       // reads per sample frame
    localparam int TAP_IDX_W = 3;       // clog2(NUM_TAPS)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/reverb_dl_addr_wrap.sv
`default_nettype none
// ============================================================================
//  Module   : reverb_dl_addr_wrap
//  Purpose  : Combinational "pointer minus delay, modulo LINE_DEPTH" for a
//             circular delay line. Delays beyond the line length are clamped
//             to LINE_DEPTH-1 so the result always lands inside the line.
//  Ports    : i_ptr   - current (pre-increment) write pointer, < LINE_DEPTH
//             i_delay - requested delay in samples (any value)
//             o_addr  - read address, always < LINE_DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module reverb_dl_addr_wrap
    import reverb_dl_pkg::*;
#(
    parameter int LINE_DEPTH = DEPTH,
    parameter int PTR_W      = ADDR_W
) (
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [PTR_W-1:0] i_delay,
    output logic [PTR_W-1:0] o_addr
);

    // One extra bit so ptr + LINE_DEPTH cannot overflow before the subtract.
    localparam int                 c_EXT_W = PTR_W + 1;
    localparam logic [c_EXT_W-1:0] c_DEPTH = c_EXT_W'(LINE_DEPTH);
    localparam logic [c_EXT_W-1:0] c_MAX_D = c_EXT_W'(LINE_DEPTH - 1);

    logic [c_EXT_W-1:0] w_ptr;
    logic [c_EXT_W-1:0] w_delay;
    logic [c_EXT_W-1:0] w_d;

    always_comb begin
        w_ptr   = {1'b0, i_ptr};
        w_delay = {1'b0, i_delay};
        w_d     = (w_delay > c_MAX_D) ? c_MAX_D : w_delay;
        // Both branches are < LINE_DEPTH, so the top bit is always zero.
        o_addr  = PTR_W'((w_ptr >= w_d) ? (w_ptr - w_d) : (w_ptr + c_DEPTH - w_d));
    end

endmodule
`default_nettype wire

// File: rtl/reverb_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reverb_delay_line_ctrl
//  Purpose  : Runs one memory port as a circular reverb delay line. Each
//             accepted sample is written at the write pointer, then NUM_TAPS
//             words are read back at programmable delays behind it.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             sample_valid/_data    - incoming sample strobe and word
//             cfg_wr/_idx/_delay    - shadow delay register write
//             mem_*                 - memory master port (1-cycle read latency)
//             tap_valid/_idx/_data  - delayed samples out
//             frame_done            - with the last tap of a frame
//             busy                  - frame in progress
//             overrun               - sticky: sample arrived while busy
//  Revision : 1.0 - initial release
// ============================================================================
module reverb_delay_line_ctrl
    import reverb_dl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [DATA_W-1:0]    sample_data,
    input  logic                 cfg_wr,
    input  logic [TAP_IDX_W-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_delay,
    output logic [ADDR_W-1:0]    mem_address,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_writedata,
    output logic [7:0]           mem_byteenable,
    input  logic [DATA_W-1:0]    mem_readdata,
    output logic                 tap_valid,
    output logic [TAP_IDX_W-1:0] tap_idx,
    output logic [DATA_W-1:0]    tap_data,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [TAP_IDX_W-1:0] c_LAST_TAP  = TAP_IDX_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0]    c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e                 r_state;
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_frame_ptr;   // pointer value the frame was written at
    logic [DATA_W-1:0]      r_sample;
    logic [TAP_IDX_W-1:0]   r_k;
    logic [ADDR_W-1:0]      r_shadow [NUM_TAPS];
    logic [ADDR_W-1:0]      r_active [NUM_TAPS];
    logic                   r_tap_valid;
    logic [TAP_IDX_W-1:0]   r_tap_idx;
    logic                   r_frame_done;
    logic                   r_overrun;

    logic                   w_accept;
    logic [ADDR_W-1:0]      w_tap_addr;

    assign w_accept = (r_state == IDLE) && sample_valid;

    reverb_dl_addr_wrap #(
        .LINE_DEPTH (DEPTH),
        .PTR_W      (ADDR_W)
    ) u_addr_wrap (
        .i_ptr   (r_frame_ptr),
        .i_delay (r_active[r_k]),
        .o_addr  (w_tap_addr)
    );

    // Shadow delays are writable at any time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) r_shadow[i] <= '0;
        end else if (cfg_wr) begin
            r_shadow[cfg_idx] <= cfg_delay;
        end
    end

    // Active delays snapshot at frame start; a coincident cfg write is
    // forwarded so it takes part in the frame being started.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) r_active[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_active[i] <= (cfg_wr && (cfg_idx == TAP_IDX_W'(i))) ? cfg_delay : r_shadow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_frame_ptr <= '0;
            r_sample    <= '0;
            r_k         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_sample    <= sample_data;
                        r_frame_ptr <= r_wr_ptr;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    r_wr_ptr <= (r_wr_ptr == c_LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
                    r_k      <= '0;
                    r_state  <= READ;
                end
                READ: begin
                    r_k <= r_k + 1'b1;
                    if (r_k == c_LAST_TAP) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives one cycle after its address, so tap qualifiers are
    // the read-phase signals delayed by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap_valid  <= 1'b0;
            r_tap_idx    <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_tap_valid  <= (r_state == READ);
            r_tap_idx    <= (r_state == READ) ? r_k : '0;
            r_frame_done <= (r_state == READ) && (r_k == c_LAST_TAP);
            if (sample_valid && (r_state != IDLE)) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = 8'h00;
        case (r_state)
            WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = r_wr_ptr;
                mem_writedata  = r_sample;
                mem_byteenable = 8'hFF;
            end
            READ: begin
                mem_chipselect = 1'b1;
                mem_address    = w_tap_addr;
                mem_byteenable = 8'hFF;
            end
            default: begin
            end
        endcase
    end

    assign tap_valid  = r_tap_valid;
    assign tap_idx    = r_tap_idx;
    assign tap_data   = r_tap_valid ? mem_readdata : '0;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
